hamdec_pipe: RTL and testbench
==============================

Name: hamdec_pipe

Overview:
- Parametrised, pipelined Hamming decoder; successor to the fixed 5-bit/9-bit combinational decoder.
- Accepts one codeword per cycle over a valid/ready stream and performs single-error correction (SEC), or SEC plus double-error detection (SECDED).
- Emits corrected data with an error position and status flags, and keeps saturating error counters.
- Sits between the codeword source and the counting/display logic.

Parameters:
- K, 5: information bits.
- SECDED, 0: 1 adds an overall-parity bit and double-error detection.
- CNT_W, 8: width of each error counter.
- R (derived, localparam): smallest R with 2^R >= K+R+1; K=5 gives R=4.
- N (derived): K+R+SECDED, the codeword width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  codeword present.
- in_ready  out  1  block accepts the codeword this cycle.
- in_cw  in  N  codeword; position p (1-based) is in_cw[p-1]. Parity bits sit at positions 1,2,4,8,...; data bits fill the remaining positions, LSB at the lowest. With SECDED=1, in_cw[N-1] is even overall parity.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  K  corrected information bits.
- out_err_pos  out  R+1  1-based position of the corrected bit; 0 = none.
- out_corrected  out  1  a single error was corrected.
- out_uncorr  out  1  uncorrectable error; out_data is the raw, uncorrected data.
- clr_cnt  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of corrected words.
- uncorr_cnt  out  CNT_W  count of uncorrectable words.

Behaviour:
- Reset (async on rst_n low): both stage valids = 0, all out_* = 0, counters = 0. In-flight words are discarded. No output appears until new words are accepted after rst_n rises.
- Pipeline, 2 stages:
  - S1 registers the extracted data, syndrome and overall-parity result.
  - S2 registers the corrected data and flags.
  - Latency: 2 cycles from accept (in_valid & in_ready) to out_valid when out_ready stays high.
  - Throughput: 1 word per cycle.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational).
  - Outputs hold stable while out_valid & !out_ready.
  - No word is dropped or duplicated, and order is preserved.
- Syndrome: bit i = XOR of all positions p (1..K+R) with bit i of p set.
- SEC mode (SECDED=0):
  - syndrome 0: clean.
  - syndrome 1..K+R: flip that position; err_pos = syndrome; corrected = 1.
  - syndrome > K+R: uncorr = 1; err_pos = 0.
- SECDED mode (pm = overall-parity mismatch):
  - syn=0, pm=0: clean.
  - syn≠0, pm=1: single error; correct as in SEC mode. An out-of-range syndrome is uncorrectable.
  - syn≠0, pm=0: double error; uncorr = 1.
  - syn=0, pm=1: parity-bit error; err_pos = N; corrected = 1; data unchanged.
- Counters:
  - Increment on the output handshake (out_valid & out_ready) only.
  - Saturate at all-ones.
  - clr_cnt wins over a simultaneous increment.

Decomposition:
- Shared include hamming_defs.vh: function calc_r(K), function is_pow2(p), and a data-position map function.
- Sub-module hamming_syndrome (combinational, parameters K and R): in_cw → syndrome and extracted data. Reused by the future encoder's check.

Test Plan:
- K=5, SEC; in_cw=9'b000001000 → out_data 00000, err_pos 4, corrected 1, two cycles after accept.
- Clean 9'b000000111 → out_data 00001, err_pos 0, corrected 0, uncorr 0.
- Back-to-back stream of 9'b001000111, 9'b100011001, 9'b000011100 with out_ready held at 1 → one result per cycle:
  - 00001 at pos 7;
  - 00010 at pos 9;
  - 00011 at pos 2.
  - corr_cnt = 3.
- 9'b100100000 (syndrome 15) → uncorr 1, out_data 10100, err_pos 0, uncorr_cnt increments.
- Backpressure: out_ready=0 for 4 cycles while in_valid=1 → in_ready drops once both stages are full. Releasing out_ready delivers the words in order with outputs stable while stalled.
- SECDED K=5, N=10: two-bit error → uncorr 1. Error on bit 10 only → err_pos 10, corrected 1. Assert rst_n low mid-stream → out_valid 0 immediately, counters 0. clr_cnt together with an increment → counter 0.

Source files
------------

// File: rtl/hamdec_pipe_pkg.sv
// Shared Hamming helpers: check-bit count, position maps and decode status.
package hamdec_pipe_pkg;

   typedef enum logic [1:0] {
      DecClean,
      DecCorrected,
      DecUncorr
   } dec_status_e;

   // Smallest r with 2^r >= k + r + 1.
   function automatic int unsigned calc_r(input int unsigned k);
      int unsigned r;
      r = 1;
      while ((32'd1 << r) < (k + r + 32'd1)) r++;
      return r;
   endfunction

   function automatic bit is_pow2(input int unsigned p);
      return (p != 0) && ((p & (p - 32'd1)) == 0);
   endfunction

   // 1-based codeword position of data bit idx (data fills non-power-of-two slots).
   function automatic int unsigned data_pos(input int unsigned idx);
      int unsigned cnt;
      int unsigned pos;
      cnt = 0;
      pos = 0;
      for (int unsigned p = 1; p < 64; p++) begin
         if (!is_pow2(p)) begin
            if (cnt == idx && pos == 0) pos = p;
            cnt++;
         end
      end
      return pos;
   endfunction

   // Positions 1..kr whose index has bit b set; bit p-1 of the mask is position p.
   function automatic logic [63:0] syn_mask(input int unsigned kr, input int unsigned b);
      logic [63:0] m;
      m = '0;
      for (int unsigned p = 1; p < 64; p++) begin
         if (p <= kr && ((p >> b) & 32'd1) == 32'd1) m = m | (64'd1 << (p - 1));
      end
      return m;
   endfunction

   // One-hot mask selecting the codeword bit that carries data bit idx.
   function automatic logic [63:0] data_mask(input int unsigned idx);
      return 64'd1 << (data_pos(idx) - 1);
   endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome and data extraction for a K+R-bit Hamming codeword.
module hamming_syndrome
   import hamdec_pipe_pkg::*;
#(
   parameter int unsigned K = 5,
   parameter int unsigned R = 4
) (
   input  logic [K+R-1:0] cw,
   output logic [R-1:0]   syndrome,
   output logic [K-1:0]   data
);

   localparam int unsigned KR = K + R;

   for (genvar i = 0; i < R; i++) begin : g_syn
      localparam logic [63:0] Mask = syn_mask(KR, i);
      assign syndrome[i] = ^(cw & Mask[KR-1:0]);
   end

   for (genvar d = 0; d < K; d++) begin : g_data
      localparam logic [63:0] Mask = data_mask(d);
      assign data[d] = |(cw & Mask[KR-1:0]);
   end

endmodule

// File: rtl/hamdec_pipe.sv
// Two-stage pipelined Hamming SEC / SECDED decoder with saturating error counters.
module hamdec_pipe
   import hamdec_pipe_pkg::*;
#(
   parameter int unsigned K      = 5,
   parameter int unsigned SECDED = 0,
   parameter int unsigned CNT_W  = 8,
   localparam int unsigned R     = calc_r(K),
   localparam int unsigned N     = K + R + SECDED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_cw,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [K-1:0]     out_data,
   output logic [R:0]       out_err_pos,
   output logic             out_corrected,
   output logic             out_uncorr,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt
);

   localparam int unsigned KR = K + R;

   logic           s1_adv;
   logic           s2_adv;
   logic           s1_valid;
   logic [K-1:0]   s1_data;
   logic [R-1:0]   s1_syn;
   logic           s1_pm;
   logic [R-1:0]   syn_c;
   logic [K-1:0]   data_c;
   logic           pm_c;
   logic [K-1:0]   flip_mask;
   dec_status_e    dec_status;
   logic [R:0]     dec_pos;
   logic [K-1:0]   dec_data;
   logic           out_hs;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = s1_adv;
   assign out_hs   = out_valid && out_ready;

   hamming_syndrome #(
      .K (K),
      .R (R)
   ) u_syndrome (
      .cw       (in_cw[KR-1:0]),
      .syndrome (syn_c),
      .data     (data_c)
   );

   // Overall parity covers the whole codeword including the extra bit; even parity -> 0.
   if (SECDED != 0) begin : g_pm
      assign pm_c = ^in_cw;
   end else begin : g_no_pm
      assign pm_c = 1'b0;
   end

   // Stage 1: capture extracted data, syndrome and parity mismatch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_syn   <= '0;
         s1_pm    <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_data <= data_c;
            s1_syn  <= syn_c;
            s1_pm   <= pm_c;
         end
      end
   end

   // A syndrome equal to a data position flips that data bit; parity positions never match.
   for (genvar i = 0; i < K; i++) begin : g_flip
      localparam int unsigned Pos = data_pos(i);
      assign flip_mask[i] = (s1_syn == R'(Pos));
   end

   // Classify the word from syndrome and parity mismatch.
   always_comb begin
      dec_status = DecClean;
      dec_pos    = '0;
      if (s1_syn == '0) begin
         if (s1_pm) begin
            dec_status = DecCorrected;
            dec_pos    = (R + 1)'(N);
         end
      end else if (SECDED == 0 || s1_pm) begin
         if (s1_syn <= R'(KR)) begin
            dec_status = DecCorrected;
            dec_pos    = {1'b0, s1_syn};
         end else begin
            dec_status = DecUncorr;
         end
      end else begin
         dec_status = DecUncorr;
      end
   end

   assign dec_data = (dec_status == DecCorrected) ? (s1_data ^ flip_mask) : s1_data;

   // Stage 2: register corrected result; holds while downstream stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_err_pos   <= '0;
         out_corrected <= 1'b0;
         out_uncorr    <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data      <= dec_data;
            out_err_pos   <= dec_pos;
            out_corrected <= (dec_status == DecCorrected);
            out_uncorr    <= (dec_status == DecUncorr);
         end
      end
   end

   // Saturating counters bumped on delivered words; clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else if (clr_cnt) begin
         corr_cnt   <= '0;
         uncorr_cnt <= '0;
      end else begin
         if (out_hs && out_corrected && corr_cnt != '1) corr_cnt <= corr_cnt + CNT_W'(1);
         if (out_hs && out_uncorr && uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hamdec_pipe.sv
// Directed bench: one SEC (K=5, N=9) and one SECDED (K=5, N=10) decoder instance.
module tb_hamdec_pipe;

   logic       clk;
   logic       rst_n;

   logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [8:0] s_in_cw;
   logic [4:0] s_out_data, s_out_err_pos;
   logic       s_out_corrected, s_out_uncorr, s_clr_cnt;
   logic [7:0] s_corr_cnt, s_uncorr_cnt;

   logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready;
   logic [9:0] d_in_cw;
   logic [4:0] d_out_data, d_out_err_pos;
   logic       d_out_corrected, d_out_uncorr, d_clr_cnt;
   logic [7:0] d_corr_cnt, d_uncorr_cnt;

   int n_checks = 0;
   int n_errors = 0;

   hamdec_pipe #(.K(5), .SECDED(0), .CNT_W(8)) u_sec (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (s_in_valid),
      .in_ready      (s_in_ready),
      .in_cw         (s_in_cw),
      .out_valid     (s_out_valid),
      .out_ready     (s_out_ready),
      .out_data      (s_out_data),
      .out_err_pos   (s_out_err_pos),
      .out_corrected (s_out_corrected),
      .out_uncorr    (s_out_uncorr),
      .clr_cnt       (s_clr_cnt),
      .corr_cnt      (s_corr_cnt),
      .uncorr_cnt    (s_uncorr_cnt)
   );

   hamdec_pipe #(.K(5), .SECDED(1), .CNT_W(8)) u_ded (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (d_in_valid),
      .in_ready      (d_in_ready),
      .in_cw         (d_in_cw),
      .out_valid     (d_out_valid),
      .out_ready     (d_out_ready),
      .out_data      (d_out_data),
      .out_err_pos   (d_out_err_pos),
      .out_corrected (d_out_corrected),
      .out_uncorr    (d_out_uncorr),
      .clr_cnt       (d_clr_cnt),
      .corr_cnt      (d_corr_cnt),
      .uncorr_cnt    (d_uncorr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Send one isolated word and check its result two cycles after acceptance.
   task automatic send_word(input bit ded, input logic [9:0] cw, input logic [4:0] e_data,
                            input logic [4:0] e_pos, input logic e_corr, input logic e_unc);
      @(negedge clk);
      if (ded) begin
         d_in_valid = 1'b1;
         d_in_cw    = cw;
      end else begin
         s_in_valid = 1'b1;
         s_in_cw    = cw[8:0];
      end
      @(negedge clk);
      d_in_valid = 1'b0;
      s_in_valid = 1'b0;
      check("lat1_valid", 32'(ded ? d_out_valid : s_out_valid), 32'd0);
      @(negedge clk);
      if (ded) begin
         check("ded_valid", 32'(d_out_valid), 32'd1);
         check("ded_data", 32'(d_out_data), 32'(e_data));
         check("ded_pos", 32'(d_out_err_pos), 32'(e_pos));
         check("ded_corr", 32'(d_out_corrected), 32'(e_corr));
         check("ded_unc", 32'(d_out_uncorr), 32'(e_unc));
      end else begin
         check("sec_valid", 32'(s_out_valid), 32'd1);
         check("sec_data", 32'(s_out_data), 32'(e_data));
         check("sec_pos", 32'(s_out_err_pos), 32'(e_pos));
         check("sec_corr", 32'(s_out_corrected), 32'(e_corr));
         check("sec_unc", 32'(s_out_uncorr), 32'(e_unc));
      end
   endtask

   logic [8:0] str_cw   [3];
   logic [4:0] str_data [3];
   logic [4:0] str_pos  [3];
   logic [8:0] bp_cw    [4];
   logic [4:0] bp_data  [4];
   int         tx;
   int         rx;
   logic       acc;

   initial begin
      str_cw   = '{9'b001000111, 9'b100011001, 9'b000011100};
      str_data = '{5'b00001, 5'b00010, 5'b00011};
      str_pos  = '{5'd7, 5'd9, 5'd2};
      bp_cw    = '{9'b000000111, 9'b000011100, 9'b100011001, 9'b100100000};
      bp_data  = '{5'b00001, 5'b00011, 5'b00010, 5'b10100};

      rst_n = 1'b0;
      s_in_valid = 1'b0; s_in_cw = '0; s_out_ready = 1'b1; s_clr_cnt = 1'b0;
      d_in_valid = 1'b0; d_in_cw = '0; d_out_ready = 1'b1; d_clr_cnt = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(s_out_valid), 32'd0);
      check("rst_data", 32'(s_out_data), 32'd0);
      check("rst_corr_cnt", 32'(s_corr_cnt), 32'd0);
      check("rst_ded_valid", 32'(d_out_valid), 32'd0);
      rst_n = 1'b1;

      // SEC: parity-bit error, then a clean word.
      send_word(1'b0, 10'b0000001000, 5'b00000, 5'd4, 1'b1, 1'b0);
      send_word(1'b0, 10'b0000000111, 5'b00001, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      check("cnt_after_two", 32'(s_corr_cnt), 32'd1);
      s_clr_cnt = 1'b1;
      @(negedge clk);
      s_clr_cnt = 1'b0;
      check("clr_corr_cnt", 32'(s_corr_cnt), 32'd0);

      // Back-to-back stream: one result per cycle.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            check("str_valid", 32'(s_out_valid), 32'd1);
            check("str_data", 32'(s_out_data), 32'(str_data[i-2]));
            check("str_pos", 32'(s_out_err_pos), 32'(str_pos[i-2]));
         end
         if (i < 3) begin
            s_in_valid = 1'b1;
            s_in_cw    = str_cw[i];
         end else begin
            s_in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("str_corr_cnt", 32'(s_corr_cnt), 32'd3);

      // Out-of-range syndrome 15.
      send_word(1'b0, 10'b0100100000, 5'b10100, 5'd0, 1'b0, 1'b1);
      @(negedge clk);
      check("uncorr_cnt", 32'(s_uncorr_cnt), 32'd1);

      // Backpressure: four stalled cycles, then drain in order.
      tx = 0; rx = 0; acc = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         s_out_ready = (i >= 4);
         if (s_out_valid) begin
            if (s_out_ready) begin
               if (rx < 4) check("bp_order", 32'(s_out_data), 32'(bp_data[rx]));
               rx++;
            end else begin
               check("bp_hold", 32'(s_out_data), 32'(bp_data[0]));
            end
         end
         if (acc) tx++;
         if (tx < 4) begin
            s_in_valid = 1'b1;
            s_in_cw    = bp_cw[tx];
         end else begin
            s_in_valid = 1'b0;
         end
         #1;
         acc = s_in_valid && s_in_ready;
         if (i == 2 || i == 3) check("bp_in_ready", 32'(s_in_ready), 32'd0);
      end
      check("bp_rx_count", 32'(rx), 32'd4);
      check("bp_corr_cnt", 32'(s_corr_cnt), 32'd5);
      check("bp_uncorr_cnt", 32'(s_uncorr_cnt), 32'd2);

      // SECDED: single, double, overall-parity-bit error, clean.
      send_word(1'b1, 10'b1000001111, 5'b00001, 5'd4, 1'b1, 1'b0);
      send_word(1'b1, 10'b1000011111, 5'b00011, 5'd0, 1'b0, 1'b1);
      send_word(1'b1, 10'b0000000111, 5'b00001, 5'd10, 1'b1, 1'b0);
      send_word(1'b1, 10'b1000000111, 5'b00001, 5'd0, 1'b0, 1'b0);
      @(negedge clk);
      check("ded_corr_cnt", 32'(d_corr_cnt), 32'd2);
      check("ded_uncorr_cnt", 32'(d_uncorr_cnt), 32'd1);

      // Clear coincident with a counting handshake.
      @(negedge clk);
      d_in_valid = 1'b1;
      d_in_cw    = 10'b1000001111;
      @(negedge clk);
      d_in_valid = 1'b0;
      @(negedge clk);
      check("clr_hs_corr", 32'(d_out_corrected), 32'd1);
      d_clr_cnt = 1'b1;
      @(negedge clk);
      d_clr_cnt = 1'b0;
      check("clr_wins", 32'(d_corr_cnt), 32'd0);
      check("clr_wins_unc", 32'(d_uncorr_cnt), 32'd0);

      // Asynchronous reset mid-stream.
      s_out_ready = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b1;
      s_in_cw    = 9'b000001000;
      repeat (2) @(negedge clk);
      check("pre_rst_valid", 32'(s_out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(s_out_valid), 32'd0);
      check("async_corr_cnt", 32'(s_corr_cnt), 32'd0);
      check("async_uncorr_cnt", 32'(s_uncorr_cnt), 32'd0);
      s_in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_rst_idle", 32'(s_out_valid), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
